// File: rtl/regfile.sv
// Two-read / one-write RV32I register file with hardwired-zero x0 and a post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
    logic              ready_reg, ready_next;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= FIRST_IDX;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
            ready_reg   <= ready_next;
        end
    end

    // The index holds at the last register once RUN is entered.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        ready_next   = ready_reg;
        case (state_reg)
            CLEAR: begin
                if (clr_idx_reg == LAST_IDX) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end else begin
                    clr_idx_next = clr_idx_reg + ADDR_W'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Single write port shared between the clear sequencer and write-back.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx_reg;
        mem_wdata = '0;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem_we = 1'b1;
            end else if (we_i && (waddr_i != '0)) begin
                mem_we    = 1'b1;
                mem_waddr = waddr_i;
                mem_wdata = wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic              re    [2];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign re[0]    = re1_i;
    assign re[1]    = re2_i;
    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic bypass_hit;
`ifdef REGFILE_WR_BYPASS_EN
            assign bypass_hit = (state_reg == RUN) && we_i && (waddr_i != '0) &&
                                re[gi] && (raddr[gi] == waddr_i);
`else
            assign bypass_hit = 1'b0;
`endif
            always_comb begin
                rdata[gi] = '0;
                if (rst || (state_reg == CLEAR)) begin
                    rdata[gi] = '0;
                end else if (!re[gi] || (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end else if (bypass_hit) begin
                    rdata[gi] = wdata_i;
                end else begin
                    rdata[gi] = mem[raddr[gi]];
                end
            end
        end
    endgenerate

    assign rdata1_o  = rdata[0];
    assign rdata2_o  = rdata[1];
    assign ready_o   = ready_reg;
    assign clr_idx_o = clr_idx_reg;

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage RV32I core: the responder to the decode stage's two register read requests and the target of the write-back stage's register writes. It provides two combinational read ports, one synchronous write port, a hardwired-zero x0, an optional same-cycle write-to-read bypass, and a post-reset clear sequencer. The sequencer zeroes every register and holds `ready_o` low until the array is valid.

## Interface
- `DATA_W`, 32: register width (RegBus).
- `ADDR_W`, 5: register address width (RegAddrBus).
- `NUM_REGS`, 32: register count; must equal 2**ADDR_W.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `we_i` input 1: write enable from write-back.
- `waddr_i` input ADDR_W: write address.
- `wdata_i` input DATA_W: write data.
- `re1_i` input 1: read enable, port 1.
- `raddr1_i` input ADDR_W: read address, port 1.
- `rdata1_o` output DATA_W: read data, port 1; combinational.
- `re2_i` input 1: read enable, port 2.
- `raddr2_i` input ADDR_W: read address, port 2.
- `rdata2_o` output DATA_W: read data, port 2; combinational.
- `ready_o` output 1: high once the clear sequence has completed; pipeline control stalls fetch/decode while it is low.
- `clr_idx_o` output ADDR_W: current clear index; debug and verification visibility only.

## Operation
- FSM states: CLEAR, RUN.
- `rst` high at a clock edge: state←CLEAR, `clr_idx_o`←1, `ready_o`←0.
- CLEAR:
  - Each cycle writes 0 to `reg[clr_idx_o]` and increments the index.
  - When the index reaches NUM_REGS-1 and is written, state←RUN and `ready_o`←1 at the same edge.
- RUN: if `we_i`=1 and `waddr_i`≠0, `reg[waddr_i]`←`wdata_i` at the edge. Writes to x0 are discarded.
- During CLEAR, `we_i` is ignored; write-back never writes while `ready_o`=0.
- Read port n, evaluated combinationally, in priority order:
  - `rst`=1 or state=CLEAR → 0.
  - `re_n`=0 → 0.
  - `raddr_n`=0 → 0.
  - Bypass hit (see Configuration) → `wdata_i`.
  - Otherwise → `reg[raddr_n]`.
- Both read ports are independent. Both may address the same register, and both may match the write address in the same cycle.
- x0 has no storage, or its storage is never read; it always returns 0.

## Timing
- Read latency: 0 cycles (combinational from address/enable to data).
- Write latency: visible on a read port at the cycle after the write edge. With bypass compiled in, it is visible in the same cycle.
- Clear sequence: NUM_REGS-1 = 31 cycles after the first edge with `rst`=0. `ready_o` rises at the 31st edge.
- Reset asserted mid-CLEAR: the sequence restarts at index 1.
- Reset asserted in RUN: re-enters CLEAR and all registers are zeroed again.
- Output reset values:
  - `rdata1_o`=0, `rdata2_o`=0.
  - `ready_o`=0.
  - `clr_idx_o`=1.
- After RUN is entered, `clr_idx_o` holds at NUM_REGS-1.

## Configuration
- `REGFILE_WR_BYPASS_EN` defined:
  - Read port n returns `wdata_i` when state=RUN, `we_i`=1, `waddr_i`≠0, `re_n`=1, and `raddr_n`=`waddr_i`.
  - This covers the write-back-to-decode hazard that the decode stage's ex/mem forwarding does not cover.
- Not defined:
  - No bypass; a same-cycle read returns the old array value.
  - Pipeline control must insert one stall for that hazard.

## Test plan
- Release `rst` → `ready_o` stays 0 for 30 cycles and is 1 at the 31st edge. Reading any address in RUN returns 0x00000000.
- In RUN, write x5=0xDEADBEEF, then next cycle read port1 x5 → 0xDEADBEEF. Read with `re1_i`=0 → 0.
- Write x0=0xFFFFFFFF → both ports reading x0 return 0, including the same cycle with the bypass compiled in.
- Same cycle: write x7=0x12345678 while both ports read x7 with the old value 0x1.
  - With `REGFILE_WR_BYPASS_EN`: both ports = 0x12345678.
  - Without it: both ports = 0x1, then 0x12345678 the next cycle.
- Assert `rst` at clear index 12, then release → the sequence restarts at index 1. `ready_o` rises 31 cycles after release.
- Write x3=0xA5A5A5A5, then pulse `rst` one cycle, then wait for `ready_o` → x3 reads 0.
